bip_sequencer: RTL and testbench

- Multi-cycle control sequencer for the BIP-I datapath.
- Replaces the single-cycle PC-plus-decoder control path with a FETCH/DECODE/EXEC state machine, so synchronous data RAM reads get a full cycle.
- Adds start, single-step and halt handling for the debug unit, plus a retired-instruction counter.
- Sits between the program memory, the data RAM and the accumulator/ALU datapath.

---
 rtl/bip_pkg.sv | 38 +++
 rtl/bip_opdecode.sv | 51 +++++
 rtl/bip_sequencer.sv | 133 +++++++++++++
 tb/tb_bip_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP-I multi-cycle control path:
// opcodes, accumulator mux encodings, sequencer states, decode bundle.
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        PAUSE,
        HALT
    } state_t;

    typedef struct packed {
        logic [1:0] sela;
        logic       selb;
        logic       op;
        logic       wracc;
        logic       wrram;
        logic       rdram;
        logic       legal;
        logic       halt;
    } ctrl_t;

endpackage

// File: rtl/bip_opdecode.sv
// Opcode to datapath-control map; purely combinational,
// the sequencer decides in which state each field is honoured.
module bip_opdecode
    import bip_pkg::*;
(
    input  logic [4:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl       = '0;
        ctrl.legal = 1'b1;
        unique case (opcode)
            OP_HLT:  ctrl.halt = 1'b1;
            OP_STO:  ctrl.wrram = 1'b1;
            OP_LD: begin
                ctrl.wracc = 1'b1;
                ctrl.rdram = 1'b1;
                ctrl.sela  = SELA_RAM;
            end
            OP_LDI: begin
                ctrl.wracc = 1'b1;
                ctrl.sela  = SELA_IMM;
            end
            OP_ADD: begin
                ctrl.wracc = 1'b1;
                ctrl.rdram = 1'b1;
                ctrl.sela  = SELA_ALU;
            end
            OP_ADDI: begin
                ctrl.wracc = 1'b1;
                ctrl.sela  = SELA_ALU;
                ctrl.selb  = 1'b1;
            end
            OP_SUB: begin
                ctrl.wracc = 1'b1;
                ctrl.rdram = 1'b1;
                ctrl.sela  = SELA_ALU;
                ctrl.op    = 1'b1;
            end
            OP_SUBI: begin
                ctrl.wracc = 1'b1;
                ctrl.sela  = SELA_ALU;
                ctrl.selb  = 1'b1;
                ctrl.op    = 1'b1;
            end
            default: ctrl.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/bip_sequencer.sv
// FETCH/DECODE/EXEC control sequencer for the BIP-I datapath,
// with start/step/halt debug control and a retired-instruction counter.
module bip_sequencer
    import bip_pkg::*;
#(
    parameter int PC_W  = 11,
    parameter int CNT_W = 16
)
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             StepMode,
    input  logic             Step,
    input  logic [15:0]      Instruction,
    output logic [PC_W-1:0]  Addr,
    output logic [1:0]       SelA,
    output logic             SelB,
    output logic             WrAcc,
    output logic             Op,
    output logic             WrRam,
    output logic             RdRam,
    output logic [PC_W-1:0]  Operand,
    output logic             Halted,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [PC_W-1:0]  pc;
    logic [15:0]      ir;
    logic [CNT_W-1:0] cnt;
    logic             ill;
    ctrl_t            ctrl;

    logic [1:0] sela;
    logic       selb;
    logic       op;
    logic       wracc;
    logic       wrram;
    logic       rdram;

    bip_opdecode u_dec (
        .opcode (ir[15:11]),
        .ctrl   (ctrl)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc  <= '0;
            ir  <= '0;
            cnt <= '0;
            ill <= 1'b0;
        end else begin
            if (state == FETCH) begin
                ir <= Instruction;
            end
            if (state == DECODE && !ctrl.legal) begin
                ill <= 1'b1;
            end
            if (state == EXEC) begin
                pc <= pc + PC_ONE;
                if (cnt != '1) begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        sela     = SELA_RAM;
        selb     = 1'b0;
        op       = 1'b0;
        wracc    = 1'b0;
        wrram    = 1'b0;
        rdram    = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) state_nx = FETCH;
            end
            FETCH: state_nx = DECODE;
            DECODE: begin
                rdram = ctrl.rdram;
                if (ctrl.halt || !ctrl.legal) begin
                    state_nx = HALT;
                end else begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                sela     = ctrl.sela;
                selb     = ctrl.selb;
                op       = ctrl.op;
                wracc    = ctrl.wracc;
                wrram    = ctrl.wrram;
                state_nx = StepMode ? PAUSE : FETCH;
            end
            PAUSE: begin
                if (Step) state_nx = FETCH;
            end
            HALT: state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    // Gate with Reset so an aborted write never reaches the RAM/accumulator.
    assign SelA  = Reset ? sela : SELA_RAM;
    assign SelB  = selb  & Reset;
    assign Op    = op    & Reset;
    assign WrAcc = wracc & Reset;
    assign WrRam = wrram & Reset;
    assign RdRam = rdram & Reset;

    assign Addr       = pc;
    assign Operand    = ir[PC_W-1:0];
    assign Halted     = (state == HALT);
    assign IllegalOp  = ill;
    assign InstrCount = cnt;

endmodule

// File: tb/tb_bip_sequencer.sv
// Randomized bench for bip_sequencer; expected per-cycle control
// words come from an instruction-level model of the program flow.
module tb_bip_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        StepMode;
    logic        Step;
    logic [15:0] Instruction;
    logic [10:0] Addr;
    logic [1:0]  SelA;
    logic        SelB;
    logic        WrAcc;
    logic        Op;
    logic        WrRam;
    logic        RdRam;
    logic [10:0] Operand;
    logic        Halted;
    logic        IllegalOp;
    logic [15:0] InstrCount;

    logic [15:0] rom [0:2047];

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_cnt;
    int          cyc;
    int          wr_cycle;
    logic [10:0] wr_oper;

    bip_sequencer #(.PC_W(11), .CNT_W(16)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .StepMode    (StepMode),
        .Step        (Step),
        .Instruction (Instruction),
        .Addr        (Addr),
        .SelA        (SelA),
        .SelB        (SelB),
        .WrAcc       (WrAcc),
        .Op          (Op),
        .WrRam       (WrRam),
        .RdRam       (RdRam),
        .Operand     (Operand),
        .Halted      (Halted),
        .IllegalOp   (IllegalOp),
        .InstrCount  (InstrCount)
    );

    assign Instruction = rom[Addr];

    always #5 Clk = ~Clk;

    function automatic logic [46:0] pk(
        input logic [10:0] a, input logic [10:0] o, input logic [1:0] sa,
        input logic sb, input logic wa, input logic op, input logic wr,
        input logic rd, input logic h, input logic il, input logic [15:0] c);
        return {a, o, sa, sb, wa, op, wr, rd, h, il, c};
    endfunction

    function automatic logic [46:0] obs();
        return pk(Addr, Operand, SelA, SelB, WrAcc, Op, WrRam, RdRam,
                  Halted, IllegalOp, InstrCount);
    endfunction

    task automatic do_reset();
        Reset = 1'b0;
        Start = 1'b0;
        Step = 1'b0;
        StepMode = 1'b0;
        m_pc = '0;
        m_ir = '0;
        m_cnt = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    // Runs the loaded program from IDLE for at most max_instr instructions.
    // smode: 0 free-run, 1 single-step, 2 random per instruction.
    task automatic run_prog(input int max_instr, input int smode);
        logic [4:0]  opc;
        logic [46:0] e;
        logic        sm, alu, wa, sb, op, wr, rd;
        logic [1:0]  sa;
        int          p;
        Start = 1'b1;
        cyc = 0;
        wr_cycle = -1;
        @(negedge Clk);
        for (int k = 0; k < max_instr; k++) begin
            cyc++;
            e = pk(m_pc, m_ir[10:0], 2'b00, 0, 0, 0, 0, 0, 0, 0, m_cnt);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL fetch cyc=%0d got=%h exp=%h", cyc, obs(), e);
            end
            m_ir = rom[m_pc];
            opc = m_ir[15:11];
            Start = 1'($urandom);
            Step = 1'($urandom);
            @(negedge Clk);
            cyc++;
            rd = (opc == 5'd2) || (opc == 5'd4) || (opc == 5'd6);
            e = pk(m_pc, m_ir[10:0], 2'b00, 0, 0, 0, 0, rd, 0, 0, m_cnt);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL decode cyc=%0d got=%h exp=%h", cyc, obs(), e);
            end
            sm = (smode == 2) ? 1'($urandom) : (smode == 1);
            StepMode = sm;
            Step = 1'($urandom);
            @(negedge Clk);
            if (opc == 5'd0 || opc >= 5'd8) begin
                for (int j = 0; j < 3; j++) begin
                    cyc++;
                    e = pk(m_pc, m_ir[10:0], 2'b00, 0, 0, 0, 0, 0, 1,
                           opc >= 5'd8, m_cnt);
                    n_cmp++;
                    if (obs() !== e) begin
                        n_bad++;
                        $display("FAIL halt cyc=%0d got=%h exp=%h",
                                 cyc, obs(), e);
                    end
                    Start = 1'($urandom);
                    Step = 1'($urandom);
                    @(negedge Clk);
                end
                return;
            end
            cyc++;
            alu = (opc >= 5'd4);
            wa = (opc >= 5'd2);
            wr = (opc == 5'd1);
            sa = alu ? 2'b10 : ((opc == 5'd3) ? 2'b01 : 2'b00);
            sb = alu & opc[0];
            op = alu & opc[1];
            e = pk(m_pc, m_ir[10:0], sa, sb, wa, op, wr, 0, 0, 0, m_cnt);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL exec cyc=%0d got=%h exp=%h", cyc, obs(), e);
            end
            if (WrRam) begin
                wr_cycle = cyc;
                wr_oper = Operand;
            end
            Step = 1'b0;
            @(negedge Clk);
            m_pc = m_pc + 11'd1;
            m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            if (sm) begin
                p = $urandom_range(4, 1);
                for (int j = 0; j < p; j++) begin
                    cyc++;
                    e = pk(m_pc, m_ir[10:0], 2'b00, 0, 0, 0, 0, 0, 0, 0, m_cnt);
                    n_cmp++;
                    if (obs() !== e) begin
                        n_bad++;
                        $display("FAIL pause cyc=%0d got=%h exp=%h",
                                 cyc, obs(), e);
                    end
                    Start = 1'($urandom);
                    Step = (j == p - 1);
                    @(negedge Clk);
                end
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Start = 1'b1;
        Step = 1'b1;
        StepMode = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 47'd0) begin
            n_bad++;
            $display("FAIL reset_async got=%h exp=0", obs());
        end
        repeat (2) @(negedge Clk);
        n_cmp++;
        if (obs() !== 47'd0) begin
            n_bad++;
            $display("FAIL reset_held got=%h exp=0", obs());
        end
        Start = 1'b0;
        Step = 1'b0;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (obs() !== 47'd0) begin
            n_bad++;
            $display("FAIL reset_idle got=%h exp=0", obs());
        end
    endtask

    task automatic test_program();
        do_reset();
        rom[0] = {5'd3, 11'd5};
        rom[1] = {5'd5, 11'd3};
        rom[2] = {5'd1, 11'h010};
        rom[3] = 16'h0000;
        run_prog(10, 0);
        n_cmp++;
        if (wr_cycle !== 9) begin
            n_bad++;
            $display("FAIL prog_wr_cycle got=%0d exp=9", wr_cycle);
        end
        n_cmp++;
        if (wr_oper !== 11'h010) begin
            n_bad++;
            $display("FAIL prog_wr_operand got=%h exp=010", wr_oper);
        end
        n_cmp++;
        if ({Halted, Addr, InstrCount} !== {1'b1, 11'd3, 16'd3}) begin
            n_bad++;
            $display("FAIL prog_end got=%b/%0d/%0d exp=1/3/3",
                     Halted, Addr, InstrCount);
        end
    endtask

    task automatic test_ld();
        do_reset();
        rom[0] = {5'd2, 11'h020};
        rom[1] = 16'h0000;
        run_prog(5, 0);
        n_cmp++;
        if (InstrCount !== 16'd1) begin
            n_bad++;
            $display("FAIL ld_count got=%0d exp=1", InstrCount);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        rom[0] = {5'd3, 11'($urandom)};
        rom[1] = {5'd4, 11'($urandom)};
        rom[2] = 16'h4000;
        run_prog(10, 0);
        n_cmp++;
        if ({IllegalOp, Halted, Addr} !== {1'b1, 1'b1, 11'd2}) begin
            n_bad++;
            $display("FAIL illegal_end got=%b/%b/%0d exp=1/1/2",
                     IllegalOp, Halted, Addr);
        end
        n_cmp++;
        if (wr_cycle !== -1) begin
            n_bad++;
            $display("FAIL illegal_nowrite got=%0d exp=-1", wr_cycle);
        end
    endtask

    task automatic test_step();
        do_reset();
        for (int i = 0; i < 6; i++) rom[i] = {5'd3, 11'($urandom)};
        rom[6] = 16'h0000;
        run_prog(20, 1);
        n_cmp++;
        if ({Addr, InstrCount} !== {11'd6, 16'd6}) begin
            n_bad++;
            $display("FAIL step_end got=%0d/%0d exp=6/6", Addr, InstrCount);
        end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            n = $urandom_range(30, 8);
            for (int i = 0; i < n; i++) begin
                rom[i] = {5'($urandom_range(7, 1)), 11'($urandom)};
            end
            if (r[0]) rom[n] = {5'($urandom_range(31, 8)), 11'($urandom)};
            else rom[n] = {5'd0, 11'($urandom)};
            run_prog(n + 1, 2);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 2048; i++) rom[i] = {5'd3, 11'($urandom)};
        run_prog(2048, 0);
        n_cmp++;
        if ({Addr, InstrCount} !== {11'd0, 16'd2048}) begin
            n_bad++;
            $display("FAIL wrap got=%0d/%0d exp=0/2048", Addr, InstrCount);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rom[0] = {5'd3, 11'd9};
        rom[1] = {5'd1, 11'h055};
        rom[2] = 16'h0000;
        Start = 1'b1;
        repeat (4) @(negedge Clk);
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if ({WrRam, Addr, InstrCount} !== {1'b1, 11'd1, 16'd1}) begin
            n_bad++;
            $display("FAIL mid_pre got=%b/%0d/%0d exp=1/1/1",
                     WrRam, Addr, InstrCount);
        end
        Reset = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 47'd0) begin
            n_bad++;
            $display("FAIL mid_abort got=%h exp=0", obs());
        end
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (obs() !== 47'd0) begin
            n_bad++;
            $display("FAIL mid_idle got=%h exp=0", obs());
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
        test_reset();
        test_program();
        test_ld();
        test_illegal();
        test_step();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
